// File: rtl/pacc_pkg.sv
// Shared types and defaults for the product accumulator.
// Optional saturation build: define PACC_SAT_EN.
package pacc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } pacc_state_e;

  localparam int DW_DEF = 4;
  localparam int N_DEF  = 8;
  localparam int AW_DEF = 6;

  // Counter width; a frame of N needs indices 0..N-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CW_DEF = cnt_w(N_DEF);

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned AW-bit adder with optional clamp to all-ones.
// Overflow output reports the carry regardless of clamping.
module sat_adder #(
  parameter int AW = 6
) (
  input  logic [AW-1:0] i_a,
  input  logic [AW-1:0] i_b,
  input  logic          i_sat_en,
  output logic [AW-1:0] o_sum,
  output logic          o_ovf
);

  logic [AW:0] w_raw;

  // Full-width add, then clamp when enabled and the carry is set.
  always_comb begin
    w_raw = {1'b0, i_a} + {1'b0, i_b};
    o_ovf = w_raw[AW];
    o_sum = w_raw[AW-1:0];
    if (i_sat_en && w_raw[AW]) begin
      o_sum = {AW{1'b1}};
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator: sums N products, holds result until taken.
// Optional saturation build: define PACC_SAT_EN.
module product_accumulator
  import pacc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_sat
);

  localparam int CW = cnt_w(N);

`ifdef PACC_SAT_EN
  localparam logic SAT_ON = 1'b1;
`else
  localparam logic SAT_ON = 1'b0;
`endif

  pacc_state_e   r_state;
  pacc_state_e   w_state_nxt;
  logic [AW-1:0] r_acc;
  logic [AW-1:0] r_sum;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] w_add;
  logic [AW-1:0] w_din;
  logic          w_ovf;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_accept;
  logic          w_last;

  assign w_din    = AW'(in_data);
  assign w_accept = in_valid & w_in_ready;
  assign w_last   = (r_cnt == CW'(N - 1));

  sat_adder #(
    .AW (AW)
  ) u_add (
    .i_a      (r_acc),
    .i_b      (w_din),
    .i_sat_en (SAT_ON),
    .o_sum    (w_add),
    .o_ovf    (w_ovf)
  );

  // Next state and handshake outputs, decoded from state only.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      ACC: begin
        w_in_ready = 1'b1;
        if (in_valid && w_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ACC;
        end
      end
      default: w_state_nxt = ACC;
    endcase
    if (clear) begin
      w_state_nxt = ACC;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Running sum, sample index and latched frame result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sum <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_sum <= w_add;
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_add;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`ifdef PACC_SAT_EN
  logic r_sat_acc;
  logic r_sat_out;

  // Sticky clamp flag per frame, published with the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_acc <= 1'b0;
      r_sat_out <= 1'b0;
    end else if (clear) begin
      r_sat_acc <= 1'b0;
      r_sat_out <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_sat_out <= r_sat_acc | w_ovf;
        r_sat_acc <= 1'b0;
      end else begin
        r_sat_acc <= r_sat_acc | w_ovf;
      end
    end
  end

  assign out_sat = r_sat_out;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
  assign out_sat      = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_sum   = r_sum;

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential stage directly downstream of the combinational `multiply` block. It takes the 4-bit product stream over a valid/ready handshake and sums a fixed-length frame of N products into a registered result. It then holds that result until the consumer accepts it. Between frames it resets its running sum and sample counter.

## Interface
Parameters:
- `DW`, 4: width of incoming product samples; matches `multiply` output width.
- `N`, 8: samples per frame, N ≥ 2.
- `AW`, 6: accumulator and result width. Overflow is possible with the defaults: max sum 8 × 15 = 120 > 63.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous frame flush.
- `in_valid` in 1: upstream sample valid.
- `in_ready` out 1: block can accept a sample.
- `in_data` in DW: product sample, unsigned.
- `out_valid` out 1: frame result available.
- `out_ready` in 1: consumer accepts result.
- `out_sum` out AW: frame sum.
- `out_sat` out 1: frame saturated. Present only with `PACC_SAT_EN`; otherwise tied 0.

## Operation
- Two-state FSM:
  - ACC: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Accept happens when `in_valid & in_ready`. On each accept, `acc <= acc + in_data` (zero-extended to AW) and `cnt <= cnt + 1`.
- `cnt` width is clog2(N). When an accept occurs with `cnt == N-1`:
  - latch the final sum into `out_sum`;
  - go to HOLD;
  - set `cnt` to 0 and `acc` to 0.
- HOLD → ACC on `out_valid & out_ready`. `out_sum` keeps its value until the next frame completes.
- In HOLD, `in_valid` is ignored and no data is consumed.
- `clear` has priority over everything except reset. It forces ACC with `acc`=0, `cnt`=0, `out_valid`=0 and `out_sat`=0. `out_sum` is left unchanged.
- Without the saturation macro, arithmetic is unsigned and wraps modulo 2^AW.
- Reset values: state=ACC, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_sat`=0, `acc`=0, `cnt`=0.

## Timing
- `in_ready` is a function of state only; it does not combinationally depend on `in_valid`.
- `out_valid` rises on the edge that accepts the Nth sample, so it is visible the next cycle. Latency from the Nth accept to result is 1 cycle.
- No accept is possible in the cycle `out_valid` drops. The next frame's first sample is accepted one cycle after the output handshake at the earliest.
- Minimum frame period: N + 1 cycles.
- Gaps in `in_valid` only stall the frame; the count continues on resumption.
- If `rst_n` is asserted mid-frame or in HOLD, all outputs go to their reset values immediately and the partial frame is discarded.
- If `clear` and `out_ready` are both asserted in HOLD, `clear` wins; the result is simply dropped.

## Configuration
- `PACC_SAT_EN` defined:
  - the accumulator saturates at 2^AW − 1;
  - a sticky per-frame flag sets if any add saturates;
  - that flag is presented on `out_sat` alongside `out_sum` and cleared at frame start.
- `PACC_SAT_EN` undefined: wrap-around arithmetic, and `out_sat` is constant 0.

## Structure
- Package `pacc_pkg`:
  - state enum {ACC, HOLD};
  - default DW/N/AW localparams;
  - clog2-based count-width constant.
- Sub-module `sat_adder` (AW-bit unsigned add with a saturate enable and an overflow output). With the macro off, it is instantiated with saturate disabled.
- Top level holds the FSM, counter and registers.

## Test plan
- Eight accepts of `in_data`=3 with continuous `in_valid` and `out_ready`=1 → `out_sum`=24 with `out_valid` pulsed for 1 cycle, one cycle after the 8th accept; `in_ready`=0 for that cycle.
- Eight samples of 15:
  - with `PACC_SAT_EN` → `out_sum`=63, `out_sat`=1;
  - without → `out_sum`=56, `out_sat`=0.
- Complete a frame, hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 with `in_data`=7 → `out_valid` and `out_sum` stay stable, `in_ready`=0, and no samples are counted. The next frame of 1s gives 8.
- Samples 1,2,3,4,5,6,7,8 with `in_valid` low every other cycle → `out_sum`=36 after 15 cycles. Gaps do not affect the count.
- Three samples of 5, then `clear` pulse, then eight samples of 2 → `out_sum`=16; there is no residue from the flushed 15.
- `rst_n` low while in HOLD with `out_sum`=24 → `out_valid`=0, `out_sum`=0, `in_ready`=1 immediately, before any clock edge.
